// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding and width default for the RSA key-generation gcd path
package rsa_pkg;
  localparam int GCD_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} gcd_state_t;
endpackage

// File: rtl/gcd_rr_pick.sv
// gcd_rr_pick: rotate-priority encoder; req/rr_ptr in, valid/idx out (first requester at or after rr_ptr)
module gcd_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
  always_comb begin
    valid = |req;
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of one gcd core among NREQ requesters
// req/a_in/b_in: per-requester level request and operand slices
// done/err/result: one-hot completion pulse, timeout flag, registered result
// busy/owner: operation in flight and current or last winner
// core_ina/core_inb/core_rst_n: operands and load(low)/run(high) strobe to the core
// core_result/core_ready_n: result and active-low done flag from the core
module gcd_arbiter
  import rsa_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = GCD_WIDTH,
  parameter int TIMEOUT = 1023,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic [IW-1:0]     owner,
  output logic [WIDTH-1:0]  core_ina,
  output logic [WIDTH-1:0]  core_inb,
  output logic              core_rst_n,
  input  logic [WIDTH-1:0]  core_result,
  input  logic              core_ready_n
);
  localparam int CW = $clog2(TIMEOUT + 1);
  gcd_state_t state, state_d;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [WIDTH-1:0] ina_d, inb_d, result_d;
  logic [IW-1:0] owner_d, rr_ptr, rr_d, pick_idx;
  logic [NREQ-1:0] done_d;
  logic [CW-1:0] cnt, cnt_d;
  logic pick_valid, crst_d, busy_d, err_d, timed_out;

  for (genvar i = 0; i < NREQ; i++) begin : g_op
    assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
    assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
  end

  gcd_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );

  // ready wins over timeout when both land in the same cycle
  assign timed_out = core_ready_n && cnt == CW'(TIMEOUT);

  always_comb begin
    state_d = state;
    owner_d = owner;
    ina_d = core_ina;
    inb_d = core_inb;
    crst_d = core_rst_n;
    busy_d = busy;
    done_d = '0;
    err_d = 1'b0;
    result_d = result;
    rr_d = rr_ptr;
    cnt_d = cnt;
    case (state)
      IDLE: if (pick_valid) begin
        state_d = LOAD;
        owner_d = pick_idx;
        ina_d = a_arr[pick_idx];
        inb_d = b_arr[pick_idx];
        busy_d = 1'b1;
      end
      LOAD: begin
        state_d = RUN;
        crst_d = 1'b1;
        cnt_d = '0;
      end
      RUN: begin
        cnt_d = cnt + 1'b1;
        if (!core_ready_n || timed_out) begin
          state_d = DONE;
          // a requester that gave up gets no pulse; the core still ran to completion
          done_d[owner] = req[owner];
          err_d = timed_out && req[owner];
          result_d = timed_out ? '0 : core_result;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
        crst_d = 1'b0;
        rr_d = owner == IW'(NREQ - 1) ? '0 : owner + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      core_ina <= '0;
      core_inb <= '0;
      core_rst_n <= 1'b0;
      busy <= 1'b0;
      done <= '0;
      err <= 1'b0;
      result <= '0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      core_ina <= ina_d;
      core_inb <= inb_d;
      core_rst_n <= crst_d;
      busy <= busy_d;
      done <= done_d;
      err <= err_d;
      result <= result_d;
      rr_ptr <= rr_d;
      cnt <= cnt_d;
    end
  end
endmodule
